// File: rtl/bus_target.sv
// bus_target: word-addressed bus responder with a byte-writable RAM and a FIFO-fed 8N1 UART transmitter.
// Latency: read data is registered and valid one cycle after the address; writes commit at that same edge.
// Backpressure: none. A push into a full TX FIFO is dropped and raises the sticky overflow flag.
// Optional: define BUS_TARGET_CYCLE_COUNTER_EN to add the 64-bit cycle counter at I/O offsets 1 and 2.
module bus_target #(
  parameter int    RAM_LOG      = 12,
  parameter string INIT_FILE    = "",
  parameter int    FIFO_LOG     = 4,
  parameter int    CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  output logic [31:0] bus_data_r,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic        uart_tx
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                DEPTH     = 1 << FIFO_LOG;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Address decode: bit 29 picks I/O; RAM and I/O both alias over the ignored bits.
  logic                is_io;
  logic [RAM_LOG-1:0]  ram_idx;
  logic [1:0]          io_off;
  logic                unused_addr;
  assign is_io       = bus_addr[29];
  assign ram_idx     = bus_addr[RAM_LOG-1:0];
  assign io_off      = bus_addr[1:0];
  assign unused_addr = ^bus_addr;

  logic [31:0] mem [0:(1<<RAM_LOG)-1];
  logic [31:0] ram_q;
  logic [31:0] io_q;
  logic        sel_io_q;

  // RAM port: read-first, never gated by reset so the boot fetch of word 0 works; writes blocked in reset.
  always_ff @(posedge clock) begin
    ram_q <= mem[ram_idx];
    if (!reset && !is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_mask_w[i]) mem[ram_idx][8*i +: 8] <= bus_data_w[8*i +: 8];
      end
    end
  end

  // TX FIFO storage and control
  logic [7:0]          fifo_mem [0:DEPTH-1];
  logic [FIFO_LOG-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG:0]   count;
  logic                fifo_full, fifo_empty, overflow;
  logic                push_req, push, pop;
  logic [1:0]          state;
  logic                tx_busy;

  assign fifo_full  = (count == (FIFO_LOG+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = !reset && is_io && (io_off == 2'd0) && bus_mask_w[0];
  assign push       = push_req && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign tx_busy    = (state != S_IDLE);

  // FIFO data array; push is already suppressed during reset.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= bus_data_w[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (full is judged before any same-cycle pop).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && fifo_full) overflow <= 1'b1;
    end
  end

  // UART transmitter; uart_tx is registered from the current state, so it trails the state by one cycle.
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              baud_done;
  assign baud_done = (baud == BAUD_LAST);

  // TX state machine with per-state baud timing
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            shift <= fifo_mem[rd_ptr];
            baud  <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          uart_tx <= 1'b0;
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          uart_tx <= shift[bit_idx];
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          if (baud_done) begin
            baud  <= '0;
            state <= S_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end

  logic [31:0] cnt_lo, cnt_hi;
`ifdef BUS_TARGET_CYCLE_COUNTER_EN
  logic [63:0] cycle_cnt;
  logic [31:0] cnt_hi_shadow;
  // Free-running counter; touching offset 1 snapshots the high word so a lo-then-hi read is atomic.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt     <= '0;
      cnt_hi_shadow <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (is_io && io_off == 2'd1) cnt_hi_shadow <= cycle_cnt[63:32];
    end
  end
  assign cnt_lo = cycle_cnt[31:0];
  assign cnt_hi = cnt_hi_shadow;
`else
  assign cnt_lo = '0;
  assign cnt_hi = '0;
`endif

  logic [31:0] io_rdata;
  // I/O read mux, evaluated on pre-edge state (read-first)
  always_comb begin
    io_rdata = '0;
    case (io_off)
      2'd0:    io_rdata = {28'b0, overflow, tx_busy, fifo_empty, fifo_full};
      2'd1:    io_rdata = cnt_lo;
      2'd2:    io_rdata = cnt_hi;
      default: io_rdata = '0;
    endcase
  end

  // Register the I/O read and the source select alongside the RAM read
  always_ff @(posedge clock) begin
    io_q     <= io_rdata;
    sel_io_q <= is_io;
  end

  assign bus_data_r = sel_io_q ? io_q : ram_q;

endmodule

// File: tb/tb_bus_target.sv
// Randomised bench for bus_target: a transaction-level model predicts each read and the UART line,
// expectations go into a scoreboard queue, and a negedge monitor pops and compares.
module tb_bus_target;
  localparam int          RAM_LOG  = 6;
  localparam int          NW       = 1 << RAM_LOG;
  localparam int          FIFO_LOG = 2;
  localparam int          DEPTH    = 1 << FIFO_LOG;
  localparam int          C        = 4;
  localparam logic [29:0] IO       = 30'h2000_0000;
`ifdef BUS_TARGET_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_r;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic        uart_tx;

  bus_target #(
    .RAM_LOG(RAM_LOG), .INIT_FILE(""), .FIFO_LOG(FIFO_LOG), .CLKS_PER_BIT(C)
  ) dut (
    .clock(clock), .reset(reset), .bus_addr(bus_addr), .bus_data_r(bus_data_r),
    .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w), .uart_tx(uart_tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    logic        line;
    string       name;
    longint      edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_ram [NW];
  bit          m_known [NW];
  logic [7:0]  m_fifo[$];
  longint      m_edge = 0;
  longint      m_s    = -1;     // edge at which the current/last frame was popped
  logic [7:0]  m_byte = 8'h00;
  bit          m_ovf  = 1'b0;
  logic [63:0] m_cnt  = 64'd0;
  logic [31:0] m_shadow = 32'd0;

  // One bus cycle: drive, let the DUT sample, predict the response, advance the model.
  task automatic cyc(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
    exp_t   e;
    longint ed;
    int     t;
    bit     busy, pop, full, io;
    logic [RAM_LOG-1:0] idx;
    reset = r; bus_addr = a; bus_data_w = d; bus_mask_w = m;
    @(posedge clock);
    ed = m_edge + 1;
    m_edge = ed;
    io   = a[29];
    idx  = a[RAM_LOG-1:0];
    busy = (m_s >= 0) && (ed > m_s) && (ed <= m_s + 10*C);
    full = (m_fifo.size() == DEPTH);
    e.edge_no = ed;
    e.chk = 1'b1;
    if (!io) begin
      e.name = "ram_rd";
      e.chk  = m_known[idx];
      e.data = m_ram[idx];
    end else begin
      e.data = 32'd0;
      case (a[1:0])
        2'd0: begin e.name = "status"; e.data = {28'd0, m_ovf, busy, m_fifo.size() == 0, full}; end
        2'd1: begin e.name = "cnt_lo"; e.data = CNT_EN ? m_cnt[31:0] : 32'd0; end
        2'd2: begin e.name = "cnt_hi"; e.data = CNT_EN ? m_shadow : 32'd0; end
        default: e.name = "io_rsvd";
      endcase
    end
    // Line after this edge reflects where the frame was during the cycle before it.
    if (r || m_s < 0) e.line = 1'b1;
    else begin
      t = int'(ed - 1 - m_s);
      if (t < C)          e.line = 1'b0;
      else if (t < 9*C)   e.line = m_byte[(t - C) / C];
      else                e.line = 1'b1;
    end
    if (r) begin
      m_fifo.delete();
      m_s = -1; m_ovf = 1'b0; m_cnt = 64'd0; m_shadow = 32'd0;
    end else begin
      pop = !busy && (m_fifo.size() > 0);
      if (pop) begin m_byte = m_fifo.pop_front(); m_s = ed; end
      if (io && a[1:0] == 2'd0 && m[0]) begin
        if (full) m_ovf = 1'b1;
        else      m_fifo.push_back(d[7:0]);
      end
      if (!io) begin
        for (int i = 0; i < 4; i++) if (m[i]) m_ram[idx][8*i +: 8] = d[8*i +: 8];
        if (m == 4'hF) m_known[idx] = 1'b1;
      end
      if (CNT_EN && io && a[1:0] == 2'd1) m_shadow = m_cnt[63:32];
      m_cnt = m_cnt + 64'd1;
    end
    sb.push_back(e);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest outstanding expectation, away from the active edge.
  exp_t mon_e;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.chk) begin
        checks++;
        if (bus_data_r !== mon_e.data) begin
          errors++;
          $display("FAIL %s edge %0d: got %08h expected %08h", mon_e.name, mon_e.edge_no, bus_data_r, mon_e.data);
        end
      end
      checks++;
      if (uart_tx !== mon_e.line) begin
        errors++;
        $display("FAIL uart_tx edge %0d: got %b expected %b", mon_e.edge_no, uart_tx, mon_e.line);
      end
    end
  end

  function automatic logic [29:0] rand_io(input logic [1:0] off);
    return {1'b1, 27'($urandom), off};
  endfunction

  initial begin
    int sel;
    reset = 1'b1; bus_addr = '0; bus_data_w = '0; bus_mask_w = '0;
    repeat (3) cyc(30'd0, 32'd0, 4'h0, 1'b1);
    cyc(IO, 32'd0, 4'h0, 1'b0);                        // post-reset status
    for (int i = 0; i < NW; i++) cyc(30'(i), $urandom, 4'hF, 1'b0);

    // Boot fetch of word 0 through reset; writes during reset must not land
    cyc(30'd0, 32'h0000_0013, 4'hF, 1'b0);
    repeat (3) cyc(30'd0, 32'hDEAD_BEEF, 4'hF, 1'b1);
    cyc(IO, 32'd0, 4'h0, 1'b0);
    cyc(30'd0, 32'd0, 4'h0, 1'b0);

    // Byte lane write, read-during-write, aliased read
    cyc(30'd5, 32'h1122_3344, 4'hF, 1'b0);
    cyc(30'd5, 32'h00AB_0000, 4'b0100, 1'b0);
    cyc(30'd5, 32'd0, 4'h0, 1'b0);
    cyc(30'h0000_0045, 32'd0, 4'h0, 1'b0);

    // Single frame of 0x55, plus a mask[0]=0 write that must not push
    cyc(IO, 32'h0000_0055, 4'b0001, 1'b0);
    cyc(IO, 32'h0000_0077, 4'b1110, 1'b0);
    repeat (48) cyc(IO, 32'd0, 4'h0, 1'b0);

    // FIFO fill and overflow
    for (int b = 1; b <= 6; b++) cyc(IO, 32'(b), 4'b0001, 1'b0);
    repeat (5*41 + 10) cyc(IO, 32'd0, 4'h0, 1'b0);

    // Reset during data bit 3 with a second byte still queued
    cyc(IO, 32'h0000_00A5, 4'b0001, 1'b0);
    cyc(IO, 32'h0000_003C, 4'b0001, 1'b0);
    repeat (17) cyc(IO, 32'd0, 4'h0, 1'b0);
    cyc(IO, 32'd0, 4'h0, 1'b1);
    repeat (60) cyc(IO, 32'd0, 4'h0, 1'b0);

    // Cycle counter: reset, ten idle cycles, then low then high word
    cyc(IO | 30'd3, 32'd0, 4'h0, 1'b1);
    repeat (10) cyc(IO | 30'd3, 32'hFFFF_FFFF, 4'hF, 1'b0);
    cyc(IO | 30'd1, 32'd0, 4'h0, 1'b0);
    cyc(IO | 30'd2, 32'd0, 4'h0, 1'b0);

    // Randomised traffic
    repeat (1500) begin
      sel = $urandom_range(0, 299);
      if (sel < 120)      cyc({1'b0, 29'($urandom)}, $urandom,
                              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), 1'b0);
      else if (sel < 210) cyc(rand_io(2'($urandom)), $urandom, 4'h0, 1'b0);
      else if (sel < 240) cyc(rand_io(2'd0), $urandom, 4'($urandom), 1'b0);
      else if (sel < 298) cyc(rand_io(2'($urandom_range(1, 3))), $urandom, 4'($urandom), 1'b0);
      else                cyc({1'b0, 29'($urandom)}, $urandom, 4'hF, 1'b1);
    end

    // Drain: let queued frames finish while polling status
    repeat (300) cyc(IO, 32'd0, 4'h0, 1'b0);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
